alu_requester: RTL and testbench

Synchronous initiator for the ALU operand/result interface: accepts operation commands on a valid/ready stream, buffers them in a small FIFO, drives op/a/b toward the combinational ALU one command at a time, and captures the result after a fixed settle time. Each result is returned on a valid/ready result stream with echoed operands and a sequence number for scoreboarding. The block sits between a command source (sequencer or CPU-side control) and the ALU's operand/result port.

---
 rtl/alu_requester_if.sv | 37 +++
 rtl/alu_requester.sv | 139 +++++++++++++
 tb/tb_alu_requester.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_requester_if.sv
// Command, ALU operand/result and result-stream signals of alu_requester.
// master is the requester side; slave is the command source, ALU and result consumer.
interface alu_requester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int SEQ_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OP_WIDTH-1:0]   cmd_op;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_r;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [OP_WIDTH-1:0]   res_op;
    logic [DATA_WIDTH-1:0] res_a;
    logic [DATA_WIDTH-1:0] res_b;
    logic [SEQ_WIDTH-1:0]  res_seq;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_r, res_ready,
        output cmd_ready, alu_op, alu_a, alu_b,
        output res_valid, res_data, res_op, res_a, res_b, res_seq, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_r, res_ready,
        input  cmd_ready, alu_op, alu_a, alu_b,
        input  res_valid, res_data, res_op, res_a, res_b, res_seq, busy
    );
endinterface

// File: rtl/alu_requester.sv
// Buffers ALU commands in a FIFO, drives them to a combinational ALU one at a time
// and returns each captured result with echoed operands and a sequence number.
module alu_requester #(
    parameter int DATA_WIDTH    = 32,
    parameter int OP_WIDTH      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int SEQ_WIDTH     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_requester_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t state, state_nxt;

    logic [OP_WIDTH-1:0]   fifo_op [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_a  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;

    logic [CW-1:0]         settle;
    logic [SEQ_WIDTH-1:0]  seq_cnt;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] alu_a, alu_b;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data, res_a, res_b;
    logic [OP_WIDTH-1:0]   res_op;
    logic [SEQ_WIDTH-1:0]  res_seq;

    logic push, pop, capture, fifo_empty;

    // No bypass: a full FIFO refuses even when the FSM pops in the same cycle
    assign fifo_empty    = (count == '0);
    assign bus.cmd_ready = rst_n && (count < (AW+1)'(FIFO_DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign bus.busy      = (state != IDLE) || !fifo_empty;

    assign bus.alu_op    = alu_op;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign bus.res_op    = res_op;
    assign bus.res_a     = res_a;
    assign bus.res_b     = res_b;
    assign bus.res_seq   = res_seq;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (settle == '0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    pop       = !fifo_empty;
                    state_nxt = fifo_empty ? IDLE : DRIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr] <= bus.cmd_op;
            fifo_a[wr_ptr]  <= bus.cmd_a;
            fifo_b[wr_ptr]  <= bus.cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            settle    <= '0;
            seq_cnt   <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_a     <= '0;
            res_b     <= '0;
            res_seq   <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                alu_op <= fifo_op[rd_ptr];
                alu_a  <= fifo_a[rd_ptr];
                alu_b  <= fifo_b[rd_ptr];
                settle <= CW'(SETTLE_CYCLES - 1);
            end else if (state == DRIVE && settle != '0) begin
                settle <= settle - 1'b1;
            end

            if (capture) begin
                res_data  <= bus.alu_r;
                res_op    <= alu_op;
                res_a     <= alu_a;
                res_b     <= alu_b;
                res_seq   <= seq_cnt;
                seq_cnt   <= seq_cnt + 1'b1;
                res_valid <= 1'b1;
            end else if (state == HOLD && bus.res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester: vector table plus latency, backpressure,
// sequence-wrap (second instance, SEQ_WIDTH=2) and mid-operation reset sequences.
module tb_alu_requester;
    localparam int DW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_requester_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .SEQ_WIDTH(16)) bus ();
    alu_requester_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .SEQ_WIDTH(2))  bus2 ();

    alu_requester #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .FIFO_DEPTH(4), .SETTLE_CYCLES(1), .SEQ_WIDTH(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_requester #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .FIFO_DEPTH(4), .SETTLE_CYCLES(1), .SEQ_WIDTH(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Stand-in combinational ALU
    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign bus.alu_r      = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus2.alu_r     = alu_f(bus2.alu_op, bus2.alu_a, bus2.alu_b);
    assign bus2.cmd_valid = bus.cmd_valid;
    assign bus2.cmd_op    = bus.cmd_op;
    assign bus2.cmd_a     = bus.cmd_a;
    assign bus2.cmd_b     = bus.cmd_b;
    assign bus2.res_ready = bus.res_ready;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
    } vec_t;

    typedef struct {
        vec_t v;
        int   seq;
    } exp_t;

    vec_t vecs [10];
    exp_t exp_q [$];
    int   hs_t [$];
    int   checks = 0;
    int   fails = 0;
    int   exp_seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input vec_t v);
        logic ok;
        ok = 1'b0;
        bus.cmd_op    = v.op;
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("push_accept", ok, 1);
        if (ok) begin
            exp_q.push_back('{v, exp_seq});
            exp_seq++;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Result monitor: scoreboard on handshakes, stability while stalled
    exp_t           mon_e;
    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data, prev_a, prev_b;
    logic [OW-1:0]  prev_op;
    logic [15:0]    prev_seq;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("res_valid_held", bus.res_valid, 1);
                check("res_stable_ab", {prev_a, prev_b}, {bus.res_a, bus.res_b});
                check("res_stable_dso", {prev_seq, prev_op, prev_data}, {bus.res_seq, bus.res_op, bus.res_data});
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got data %0h seq %0d, expected no result", bus.res_data, bus.res_seq);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_data", bus.res_data, mon_e.v.r);
                    check("res_op", bus.res_op, mon_e.v.op);
                    check("res_a", bus.res_a, mon_e.v.a);
                    check("res_b", bus.res_b, mon_e.v.b);
                    check("res_seq", bus.res_seq, mon_e.seq);
                    check("dut2_valid", bus2.res_valid, 1);
                    check("seq_wrap", bus2.res_seq, mon_e.seq % 4);
                    hs_t.push_back(cyc);
                end
            end
            prev_stall <= bus.res_valid && !bus.res_ready;
            prev_data  <= bus.res_data;
            prev_a     <= bus.res_a;
            prev_b     <= bus.res_b;
            prev_op    <= bus.res_op;
            prev_seq   <= bus.res_seq;
        end
    end

    initial begin
        vecs[0] = '{4'd0, 32'd5,          32'd7,          32'd12};
        vecs[1] = '{4'd1, 32'd10,         32'd3,          32'd7};
        vecs[2] = '{4'd2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
        vecs[3] = '{4'd3, 32'h0000_FFFF,  32'hFFFF_0000,  32'hFFFF_FFFF};
        vecs[4] = '{4'd4, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555};
        vecs[5] = '{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[6] = '{4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[7] = '{4'd0, 32'h8000_0000,  32'h8000_0000,  32'd0};
        vecs[8] = '{4'd2, 32'h1234_5678,  32'h0000_FFFF,  32'h0000_5678};
        vecs[9] = '{4'd7, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF};

        // Reset with a command offered
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = 32'd9;
        bus.cmd_b     = 32'd9;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_alu_zero", |{bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("rst_res_zero", |{bus.res_data, bus.res_op, bus.res_a, bus.res_b, bus.res_seq}, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        check("post_rst_res_valid", bus.res_valid, 0);
        check("post_rst_busy", bus.busy, 0);

        // Single ADD: latency and fields
        bus.res_ready = 1'b1;
        push(vecs[0]);
        check("lat_e0_valid", bus.res_valid, 0);
        tick();
        check("lat_e1_valid", bus.res_valid, 0);
        check("drive_alu_a", bus.alu_a, 5);
        check("drive_alu_b", bus.alu_b, 7);
        tick();
        check("lat_e2_valid", bus.res_valid, 1);
        check("lat_res_data", bus.res_data, 12);
        check("lat_res_ab", {bus.res_a, bus.res_b}, {32'd5, 32'd7});
        check("lat_res_seq", bus.res_seq, 0);
        wait_drain();

        // Back-to-back: one result every two cycles
        hs_t.delete();
        for (int i = 1; i <= 4; i++) push(vecs[i]);
        wait_drain();
        check("b2b_count", hs_t.size(), 4);
        for (int i = 1; i < 4; i++) check("b2b_interval", hs_t[i] - hs_t[i-1], 2);
        tick();
        check("alu_retained", {bus.alu_a, bus.alu_b}, {vecs[4].a, vecs[4].b});
        check("idle_busy", bus.busy, 0);

        // Backpressure: 4 buffered + 1 held, then full
        bus.res_ready = 1'b0;
        for (int i = 5; i <= 9; i++) push(vecs[i]);
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = 32'd1;
        bus.cmd_b     = 32'd1;
        bus.cmd_valid = 1'b1;
        check("full_cmd_ready", bus.cmd_ready, 0);
        check("full_busy", bus.busy, 1);
        check("full_res_valid", bus.res_valid, 1);
        repeat (3) begin
            tick();
            check("full_cmd_ready_hold", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        wait_drain();

        // Reset while DRIVE with two commands queued
        bus.res_ready = 1'b0;
        for (int i = 0; i <= 3; i++) push(vecs[i]);
        bus.res_ready = 1'b1;
        tick();
        check("pre_reset_pending", exp_q.size(), 3);
        check("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.res_valid, 0);
        check("mid_rst_alu_zero", |{bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        check("mid_rst_res_zero", |{bus.res_data, bus.res_op, bus.res_a, bus.res_b, bus.res_seq}, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 0);
        exp_q.delete();
        exp_seq = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("no_stale_valid", bus.res_valid, 0);
        end
        check("no_stale_busy", bus.busy, 0);
        push(vecs[1]);
        wait_drain();
        check("after_rst_seq", bus.res_seq, 0);
        check("after_rst_seq2", bus2.res_seq, 0);
        check("after_rst_data", bus.res_data, vecs[1].r);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
